fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the program counter and drives the instruction memory's address, read, write and chip-select pins.
- Instruction memory holds 16-bit words and reads combinationally.
- Assembles one-word and two-word (opcode + 16-bit immediate) instructions.
- Presents them, registered, to the IF/ID boundary, with stall and redirect control from downstream.

Parameters:
- ADDR_W, 32, PC and memory-address width.
- RESET_PC, 32'h0000_0020, first instruction address (2^5, start of instruction area).
- NEEDS_IMM, 32'h0400_0000, bit k set => opcode k carries an immediate word (default: bit 26 = LDM 5'b11010).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the whole stage this cycle.
- redirect  in  1  branch/jump/interrupt taken; load redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address.
- mem_addr  out  ADDR_W  instruction-memory address (= pc, combinational).
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable, constant 0.
- mem_cs  out  1  memory chip select.
- mem_write_data  out  16  constant 16'h0000.
- mem_read_data  in  16  word at mem_addr, valid in the same cycle.
- out_valid  out  1  IF/ID slot holds a real instruction.
- out_instr  out  16  opcode word.
- out_imm  out  16  immediate word; 0 for one-word instructions.
- out_pc  out  ADDR_W  address of the opcode word.
- out_pc_next  out  ADDR_W  address following the whole instruction (return address).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- While rst=1:
  - pc=RESET_PC, state=OP.
  - out_valid=0; out_instr, out_imm, out_pc, out_pc_next all 0.
  - mem_cs=0, mem_read=0, mem_write=0.
  - All of this takes effect immediately, without waiting for a clock edge.
- After reset: mem_cs=1, mem_read=1, mem_write=0, mem_addr=pc, combinational.
- Opcode decode: opcode = mem_read_data[15:11]. needs_imm = NEEDS_IMM[opcode].
- State OP, no stall, no redirect:
  - If !needs_imm: out_valid<=1, out_instr<=word, out_imm<=0, out_pc<=pc, out_pc_next<=pc+1, pc<=pc+1, state stays OP.
  - If needs_imm: op_reg<=word, op_pc<=pc, pc<=pc+1, state<=IMM, out_valid<=0 (bubble).
- State IMM, no stall, no redirect:
  - Current word is the immediate, and is never decoded as an opcode.
  - out_valid<=1, out_instr<=op_reg, out_imm<=word, out_pc<=op_pc, out_pc_next<=pc+1, pc<=pc+1, state<=OP.
- Latency: one-word instruction appears one cycle after its address is presented; two-word instruction appears two cycles after its opcode address. Throughput is 1 word per cycle.
- stall=1 (and redirect=0): every register holds (pc, state, op_reg, op_pc and all out_* signals). mem_addr stays stable.
- redirect=1: takes priority over stall and over any in-flight IMM state. Next edge:
  - pc<=redirect_pc, state<=OP, out_valid<=0.
  - op_reg is discarded.
  - out_instr, out_imm and out_pc hold their values, but are don't-care while out_valid=0.
- PC arithmetic: modulo 2^ADDR_W; 32'hFFFF_FFFF+1 wraps to 0. No range checking; the memory uses the low address bits.
- Reset mid-IMM: any partially assembled instruction is lost. The first fetch after release is RESET_PC.

Decomposition:
- Package fetch_pkg holds:
  - state enum {OP, IMM};
  - opcode field constants (OPC_HI=15, OPC_LO=11);
  - opcode localparams (OPC_NOP=5'b00000, OPC_LDM=5'b11010, ...);
  - the default NEEDS_IMM mask;
  - RESET_PC.
- One sub-module, fetch_pc_reg: PC register with async reset to RESET_PC and next-PC mux (redirect > stall > increment).
- The IMM state machine and the IF/ID output registers stay in fetch_unit.

Test Plan:
- Reset: hold rst 3 cycles -> mem_addr=0x20, mem_cs=0, mem_read=0, out_valid=0. Release -> mem_cs=1, mem_read=1, mem_write=0.
- Two LDMs, with mem[0x20]=0xD020, [0x21]=0x0000, [0x22]=0xD040, [0x23]=0x0002:
  - edge 1: out_valid=0;
  - edge 2: out_valid=1, out_instr=0xD020, out_imm=0x0000, out_pc=0x20, out_pc_next=0x22;
  - edge 4: out_instr=0xD040, out_imm=0x0002, out_pc=0x22.
- One-word stream, with [0x26]=0x9A20 (ADD) and [0x27]=0x0000: consecutive edges give out_instr=0x9A20 then 0x0000, out_pc 0x26 then 0x27, out_valid=1 both cycles, out_imm=0.
- Stall in IMM: stall=1 for 3 cycles while mem_addr=0x21 -> mem_addr and all outputs frozen. After release, next edge delivers instr=0xD020, imm=0x0000.
- Redirect+stall in IMM: redirect=1, stall=1, redirect_pc=0x40 -> next cycle mem_addr=0x40, out_valid=0, state OP. mem[0x40]=0x0000 is delivered the following edge.
- Async reset mid-run: assert rst between edges at pc=0x25 -> mem_addr=0x20 and out_valid=0 before the next clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic {
      ST_OP  = 1'b0,
      ST_IMM = 1'b1
   } fetch_state_e;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 11;

   localparam logic [4:0] OPC_NOP = 5'b00000;
   localparam logic [4:0] OPC_ADD = 5'b10011;
   localparam logic [4:0] OPC_LDM = 5'b11010;

   // Bit k set => opcode k is followed by a 16-bit immediate word.
   localparam logic [31:0] NEEDS_IMM_DEFAULT = 32'h0400_0000;
   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0020;

   function automatic logic [4:0] opcode_of(input logic [15:0] word);
      return word[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with async reset and next-PC select (redirect > stall > +1).
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_stall,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic [ADDR_W-1:0] o_pc
);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;

   // Next-PC select; the increment wraps modulo 2^ADDR_W.
   always_comb begin
      w_pc_nxt = r_pc + ADDR_W'(1);
      if (i_redirect) begin
         w_pc_nxt = i_redirect_pc;
      end else if (i_stall) begin
         w_pc_nxt = r_pc;
      end
   end

   // PC register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_nxt;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives instruction memory, assembles one- and two-word
// instructions and registers them into the IF/ID slot.
//
// state  | meaning
// ST_OP  | current memory word is an opcode word
// ST_IMM | current memory word is the immediate of the opcode held in r_op
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEFAULT),
   parameter logic [31:0]       NEEDS_IMM = NEEDS_IMM_DEFAULT
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_stall,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic              o_mem_cs,
   output logic [15:0]       o_mem_write_data,
   input  logic [15:0]       i_mem_read_data,
   output logic              o_out_valid,
   output logic [15:0]       o_out_instr,
   output logic [15:0]       o_out_imm,
   output logic [ADDR_W-1:0] o_out_pc,
   output logic [ADDR_W-1:0] o_out_pc_next
);

   fetch_state_e      r_state;
   fetch_state_e      w_state_nxt;
   logic [15:0]       r_op;
   logic [ADDR_W-1:0] r_op_pc;
   logic [ADDR_W-1:0] w_pc;
   logic              w_needs_imm;
   logic              w_emit;
   logic              w_capture;
   logic [15:0]       w_emit_instr;
   logic [15:0]       w_emit_imm;
   logic [ADDR_W-1:0] w_emit_pc;

   logic              r_out_valid;
   logic [15:0]       r_out_instr;
   logic [15:0]       r_out_imm;
   logic [ADDR_W-1:0] r_out_pc;
   logic [ADDR_W-1:0] r_out_pc_next;

   fetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_pc          (w_pc)
   );

   assign w_needs_imm = NEEDS_IMM[opcode_of(i_mem_read_data)];

   // Memory is enabled whenever the stage is out of reset; it never writes.
   assign o_mem_addr       = w_pc;
   assign o_mem_cs         = ~i_rst;
   assign o_mem_read       = ~i_rst;
   assign o_mem_write      = 1'b0;
   assign o_mem_write_data = 16'h0000;

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_OP;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus capture/emit strobes; redirect wins over stall and IMM.
   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_capture   = 1'b0;
      if (i_redirect) begin
         w_state_nxt = ST_OP;
      end else if (!i_stall) begin
         unique case (r_state)
            ST_OP: begin
               if (w_needs_imm) begin
                  w_state_nxt = ST_IMM;
                  w_capture   = 1'b1;
               end else begin
                  w_emit = 1'b1;
               end
            end
            ST_IMM: begin
               w_state_nxt = ST_OP;
               w_emit      = 1'b1;
            end
         endcase
      end
   end

   // Instruction fields: in IMM the memory word is the immediate, never an opcode.
   always_comb begin
      w_emit_instr = i_mem_read_data;
      w_emit_imm   = 16'h0000;
      w_emit_pc    = w_pc;
      if (r_state == ST_IMM) begin
         w_emit_instr = r_op;
         w_emit_imm   = i_mem_read_data;
         w_emit_pc    = r_op_pc;
      end
   end

   // Holds the opcode word and its address while its immediate is fetched.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_op    <= 16'h0000;
         r_op_pc <= '0;
      end else if (w_capture) begin
         r_op    <= i_mem_read_data;
         r_op_pc <= w_pc;
      end
   end

   // IF/ID output registers; data fields hold while the slot is empty.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_out_valid   <= 1'b0;
         r_out_instr   <= 16'h0000;
         r_out_imm     <= 16'h0000;
         r_out_pc      <= '0;
         r_out_pc_next <= '0;
      end else if (i_redirect) begin
         r_out_valid <= 1'b0;
      end else if (!i_stall) begin
         r_out_valid <= w_emit;
         if (w_emit) begin
            r_out_instr   <= w_emit_instr;
            r_out_imm     <= w_emit_imm;
            r_out_pc      <= w_emit_pc;
            r_out_pc_next <= w_pc + ADDR_W'(1);
         end
      end
   end

   assign o_out_valid   = r_out_valid;
   assign o_out_instr   = r_out_instr;
   assign o_out_imm     = r_out_imm;
   assign o_out_pc      = r_out_pc;
   assign o_out_pc_next = r_out_pc_next;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, corner sequences, random run.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] mem_addr;
   logic        mem_read, mem_write, mem_cs;
   logic [15:0] mem_write_data, mem_read_data;
   logic        out_valid;
   logic [15:0] out_instr, out_imm;
   logic [31:0] out_pc, out_pc_next;

   logic [15:0] mem [256];
   assign mem_read_data = mem[mem_addr[7:0]];

   int n_vec = 0;
   int n_bad = 0;

   fetch_unit dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_stall          (stall),
      .i_redirect       (redirect),
      .i_redirect_pc    (redirect_pc),
      .o_mem_addr       (mem_addr),
      .o_mem_read       (mem_read),
      .o_mem_write      (mem_write),
      .o_mem_cs         (mem_cs),
      .o_mem_write_data (mem_write_data),
      .i_mem_read_data  (mem_read_data),
      .o_out_valid      (out_valid),
      .o_out_instr      (out_instr),
      .o_out_imm        (out_imm),
      .o_out_pc         (out_pc),
      .o_out_pc_next    (out_pc_next)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic        v;
      logic [15:0] instr;
      logic [15:0] imm;
      logic [31:0] pc;
      logic [31:0] pcn;
      logic [31:0] addr;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic v, input logic [15:0] instr, input logic [15:0] imm,
                               input logic [31:0] pc, input logic [31:0] pcn, input logic [31:0] addr);
      vec_t r;
      r.stall = st; r.redirect = rd; r.rpc = rpc; r.v = v; r.instr = instr;
      r.imm = imm; r.pc = pc; r.pcn = pcn; r.addr = addr;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_slot(input string tag, input logic [15:0] instr, input logic [15:0] imm,
                           input logic [31:0] pc, input logic [31:0] pcn);
      chk({tag, ".valid"}, 32'(out_valid), 32'h1);
      chk({tag, ".instr"}, 32'(out_instr), 32'(instr));
      chk({tag, ".imm"},   32'(out_imm),   32'(imm));
      chk({tag, ".pc"},    out_pc,         pc);
      chk({tag, ".pcn"},   out_pc_next,    pcn);
   endtask

   task automatic do_reset();
      stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.addr",  mem_addr, 32'h20);
      chk("rst.cs",    32'(mem_cs), 32'h0);
      chk("rst.read",  32'(mem_read), 32'h0);
      chk("rst.write", 32'(mem_write), 32'h0);
      chk("rst.valid", 32'(out_valid), 32'h0);
      chk("rst.outs",  {out_instr, out_imm} | out_pc | out_pc_next, 32'h0);
      rst = 1'b0;
      #1;
      chk("rel.cs",    32'(mem_cs), 32'h1);
      chk("rel.read",  32'(mem_read), 32'h1);
      chk("rel.write", 32'(mem_write), 32'h0);
      chk("rel.wdata", 32'(mem_write_data), 32'h0);
   endtask

   // Reference model: transaction-level view of the fetch stage.
   logic [31:0] m_pc;
   logic [47:0] m_pend [$];
   logic        m_valid;
   logic [15:0] m_instr, m_imm;
   logic [31:0] m_opc, m_pcn;

   function automatic logic two_word(input logic [15:0] w);
      return w[15:11] == 5'b11010;
   endfunction

   task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc);
      logic [15:0] word;
      logic [47:0] p;
      word = mem[m_pc % 256];
      if (rd) begin
         m_pend.delete();
         m_valid = 1'b0;
         m_pc = rpc;
      end else if (!st) begin
         if (m_pend.size() != 0) begin
            p = m_pend.pop_front();
            m_valid = 1'b1; m_instr = p[15:0]; m_opc = p[47:16]; m_imm = word;
            m_pcn = m_pc + 32'd1;
         end else if (two_word(word)) begin
            m_pend.push_back({m_pc, word});
            m_valid = 1'b0;
         end else begin
            m_valid = 1'b1; m_instr = word; m_imm = 16'h0; m_opc = m_pc;
            m_pcn = m_pc + 32'd1;
         end
         m_pc = m_pc + 32'd1;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h20] = 16'hD020; mem[8'h21] = 16'h0000;
      mem[8'h22] = 16'hD040; mem[8'h23] = 16'h0002;
      mem[8'h24] = 16'h0001; mem[8'h25] = 16'h0003;
      mem[8'h26] = 16'h9A20; mem[8'h27] = 16'h0000;
      mem[8'h28] = 16'hD0FF; mem[8'h29] = 16'h1234;
      mem[8'h2A] = 16'hD000; mem[8'h40] = 16'h0000;
      mem[8'hFF] = 16'hD111; mem[8'h00] = 16'hABCD;

      tbl[0]  = mk(0, 0, 0,            0, 16'h0,    16'h0,    0,            0,            32'h21);
      tbl[1]  = mk(0, 0, 0,            1, 16'hD020, 16'h0000, 32'h20,       32'h22,       32'h22);
      tbl[2]  = mk(0, 0, 0,            0, 16'h0,    16'h0,    0,            0,            32'h23);
      tbl[3]  = mk(0, 0, 0,            1, 16'hD040, 16'h0002, 32'h22,       32'h24,       32'h24);
      tbl[4]  = mk(0, 0, 0,            1, 16'h0001, 16'h0000, 32'h24,       32'h25,       32'h25);
      tbl[5]  = mk(0, 0, 0,            1, 16'h0003, 16'h0000, 32'h25,       32'h26,       32'h26);
      tbl[6]  = mk(0, 0, 0,            1, 16'h9A20, 16'h0000, 32'h26,       32'h27,       32'h27);
      tbl[7]  = mk(0, 0, 0,            1, 16'h0000, 16'h0000, 32'h27,       32'h28,       32'h28);
      tbl[8]  = mk(1, 0, 0,            1, 16'h0000, 16'h0000, 32'h27,       32'h28,       32'h28);
      tbl[9]  = mk(0, 0, 0,            0, 16'h0,    16'h0,    0,            0,            32'h29);
      tbl[10] = mk(1, 0, 0,            0, 16'h0,    16'h0,    0,            0,            32'h29);
      tbl[11] = mk(0, 0, 0,            1, 16'hD0FF, 16'h1234, 32'h28,       32'h2A,       32'h2A);
      tbl[12] = mk(0, 0, 0,            0, 16'h0,    16'h0,    0,            0,            32'h2B);
      tbl[13] = mk(1, 1, 32'h40,       0, 16'h0,    16'h0,    0,            0,            32'h40);
      tbl[14] = mk(0, 0, 0,            1, 16'h0000, 16'h0000, 32'h40,       32'h41,       32'h41);
      tbl[15] = mk(0, 1, 32'hFFFFFFFF, 0, 16'h0,    16'h0,    0,            0,            32'hFFFFFFFF);
      tbl[16] = mk(0, 0, 0,            0, 16'h0,    16'h0,    0,            0,            32'h0);
      tbl[17] = mk(0, 0, 0,            1, 16'hD111, 16'hABCD, 32'hFFFFFFFF, 32'h00000001, 32'h1);

      // Vector table.
      do_reset();
      for (int i = 0; i < 18; i++) begin
         stall = tbl[i].stall; redirect = tbl[i].redirect; redirect_pc = tbl[i].rpc;
         step();
         chk($sformatf("tbl%0d.addr", i), mem_addr, tbl[i].addr);
         chk($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(tbl[i].v));
         if (tbl[i].v) chk_slot($sformatf("tbl%0d", i), tbl[i].instr, tbl[i].imm, tbl[i].pc, tbl[i].pcn);
      end
      stall = 1'b0; redirect = 1'b0;

      // Stall while waiting for the immediate: everything frozen for 3 cycles.
      do_reset();
      step();
      chk("simm.addr0", mem_addr, 32'h21);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("simm.addr",  mem_addr, 32'h21);
         chk("simm.valid", 32'(out_valid), 32'h0);
         chk("simm.outs",  {out_instr, out_imm} | out_pc | out_pc_next, 32'h0);
      end
      stall = 1'b0;
      step();
      chk_slot("simm.rel", 16'hD020, 16'h0000, 32'h20, 32'h22);

      // Redirect together with stall while in IMM.
      step();
      chk("rimm.addr0", mem_addr, 32'h23);
      redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
      step();
      chk("rimm.addr",  mem_addr, 32'h40);
      chk("rimm.valid", 32'(out_valid), 32'h0);
      redirect = 1'b0; stall = 1'b0;
      step();
      chk_slot("rimm.next", 16'h0000, 16'h0000, 32'h40, 32'h41);

      // Reset mid-IMM loses the partial instruction.
      do_reset();
      step();
      rst = 1'b1;
      #1;
      chk("rmid.addr",  mem_addr, 32'h20);
      chk("rmid.valid", 32'(out_valid), 32'h0);
      rst = 1'b0;
      step();
      chk("rmid.addr1",  mem_addr, 32'h21);
      chk("rmid.valid1", 32'(out_valid), 32'h0);
      step();
      chk_slot("rmid.out", 16'hD020, 16'h0000, 32'h20, 32'h22);

      // Asynchronous reset between edges at pc 0x25.
      do_reset();
      repeat (5) step();
      chk("arst.addr0", mem_addr, 32'h25);
      #2;
      rst = 1'b1;
      #1;
      chk("arst.addr",  mem_addr, 32'h20);
      chk("arst.valid", 32'(out_valid), 32'h0);
      chk("arst.cs",    32'(mem_cs), 32'h0);

      // Random run against the reference model.
      for (int i = 0; i < 256; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         if ($urandom_range(3) == 0) w[15:11] = 5'b11010;
         mem[i] = w;
      end
      do_reset();
      m_pc = 32'h20; m_pend.delete(); m_valid = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         logic st, rd;
         logic [31:0] rpc;
         st  = ($urandom_range(3) == 0);
         rd  = ($urandom_range(9) == 0);
         rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
         stall = st; redirect = rd; redirect_pc = rpc;
         model_step(st, rd, rpc);
         step();
         chk("rnd.addr",  mem_addr, m_pc);
         chk("rnd.valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) chk_slot("rnd", m_instr, m_imm, m_opc, m_pcn);
      end
      stall = 1'b0; redirect = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
